result_tx_serializer: RTL and testbench
=======================================

# result_tx_serializer

Drains the 32-bit words of the result matrix memory and streams them byte by byte into the UART transmitter. Runs on the system clock, sits downstream of the result memory and multiplier, and drives the `uart_tx` start/busy handshake. The control unit starts it once multiplication is complete. It pulses `done` when the last byte has left the transmitter.

## Interface
- `ADDR_W`, 4: result memory address width; at most 2^ADDR_W words.
- `DATA_W`, 32: result word width; must be a multiple of 8.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a drain; sampled only in IDLE.
- `word_count`  in  ADDR_W+1  number of words to send, 0..2^ADDR_W; latched on the accepted `start`.
- `mem_addr`  out  ADDR_W  result memory read address.
- `mem_rdata`  in  DATA_W  result memory read data; synchronous read, valid one cycle after `mem_addr` changes.
- `tx_data`  out  8  byte presented to `uart_tx`.
- `tx_start`  out  1  transmit request to `uart_tx`.
- `tx_busy`  in  1  transmitter busy, already synchronised to `clk`.
- `busy`  out  1  high whenever the block is not in IDLE.
- `done`  out  1  one-cycle pulse at the end of a drain.

## Operation
- States: IDLE, RD_ADDR, RD_WAIT, REQ, ACK_WAIT, DRAIN, NEXT.
- IDLE → RD_ADDR on `start`:
  - Latch `word_count`.
  - Clear the word index and byte index.
- If the latched count is 0, go IDLE → NEXT instead, then pulse `done` the following cycle and return to IDLE.
- RD_ADDR: drive `mem_addr` = word index, then go to RD_WAIT.
- RD_WAIT: capture `mem_rdata` into the shift register, then go to REQ.
- REQ: `tx_data` = shift[DATA_W-1 -: 8], so bytes go out MSB first. Assert `tx_start` and hold it.
- Leave REQ for ACK_WAIT in the cycle `tx_busy` is sampled high. Deassert `tx_start` on that same edge.
- ACK_WAIT: wait for `tx_busy` low.
  - When low, shift the register left by 8 and increment the byte index.
  - If the byte index was DATA_W/8-1, go to NEXT. Otherwise go back to REQ.
- NEXT: increment the word index.
  - If the new index equals the latched count, pulse `done` and go to IDLE.
  - Otherwise go to RD_ADDR.
- `tx_data` holds its value from REQ entry until the next REQ. It is never changed while `tx_start` is high.
- `start` is ignored while `busy` is high. `word_count` changes after latching have no effect.
- The word index is ADDR_W+1 bits wide, so a count of 2^ADDR_W completes without aliasing. `mem_addr` is its low ADDR_W bits.
- If `tx_busy` is already high on entry to REQ (transmitter busy with a previous frame), the block waits for `tx_busy` to fall before the REQ→ACK_WAIT test is valid. No byte is lost or duplicated.

## Timing
- Values after reset:
  - state IDLE
  - `tx_start` = 0, `done` = 0, `busy` = 0
  - `mem_addr` = 0, `tx_data` = 0x00
  - indices 0
- Reset is asynchronous. Asserting it mid-drain drops `tx_start` immediately and abandons the transfer. No `done` is issued.
- From the `start` edge, `tx_start` rises 3 cycles later (RD_ADDR, RD_WAIT, REQ entry).
- Fixed overhead per word: 3 cycles (NEXT, RD_ADDR, RD_WAIT). Per byte: 2 cycles plus the transmitter busy time.
- `done` rises on the edge after the last ACK_WAIT exit plus one (NEXT), and lasts exactly 1 cycle. `busy` falls on the same edge that `done` rises.
- Handshake: at most one `tx_start` assertion per byte. `tx_start` is high only in REQ.

## Test plan
- Reset mid-drain:
  - Assert `rst` while `tx_start` is high → `tx_start`, `busy`, `done` go to 0 within the same cycle.
  - A subsequent `start` with count 1 sends 4 fresh bytes from address 0.
- Single word: memory[0]=0x12345678, count 1, transmitter model busy for 10 cycles per byte → `tx_data` sequence 0x12, 0x34, 0x56, 0x78.
  - Exactly 4 `tx_start` rising edges.
  - One `done` pulse.
- Full matrix: count 16, memory[i]=i*0x01010101 → 64 bytes in address order, `mem_addr` 0..15.
  - `done` after the 64th byte completes.
- Zero count: `start` with `word_count`=0 → no `tx_start`, no memory reads; `done` pulse 2 cycles after `start`.
- Back-pressure: hold `tx_busy` high for 50 cycles before the first byte → `tx_start` stays high with `tx_data`=0x12 stable, and no byte is skipped.
- Ignored restart: assert `start` with `word_count`=3 during a count-1 drain → only 4 bytes are sent, and one `done` pulse.

Source files
------------

// File: rtl/result_tx_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : result_tx_serializer_if
//  Purpose  : Bundles the control, result-memory and uart_tx handshake
//             signals of the result serializer. The serializer takes the
//             master view; the surrounding system takes the slave view.
//  Revision : 1.0  initial release
// ============================================================================
interface result_tx_serializer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  // Control unit side
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  // Result memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  // uart_tx side
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    input  start, word_count, mem_rdata, tx_busy,
    output busy, done, mem_addr, tx_data, tx_start
  );

  modport slave (
    output start, word_count, mem_rdata, tx_busy,
    input  busy, done, mem_addr, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/result_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : result_tx_serializer
//  Purpose  : Reads word_count result words from a synchronous-read memory
//             and hands them to uart_tx one byte at a time, MSB byte first,
//             using the tx_start / tx_busy handshake. Pulses done once the
//             last byte has left the transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module result_tx_serializer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  result_tx_serializer_if.master bus
);

  localparam int c_bytes  = DATA_W / 8;
  localparam int c_bidx_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;

  // DRAIN is a reserved encoding; it is never entered and recovers to IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_WAIT  = 3'd2,
    REQ      = 3'd3,
    ACK_WAIT = 3'd4,
    DRAIN    = 3'd5,
    NEXT     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_W:0]       r_count;
  logic [ADDR_W:0]       r_word_idx;
  logic [c_bidx_w-1:0]   r_byte_idx;
  logic [DATA_W-1:0]     r_shift;
  logic [7:0]            r_tx_data;
  logic                  r_armed;
  logic                  r_done;

  logic [ADDR_W:0]       w_word_next;
  logic [DATA_W-1:0]     w_shift_next;
  logic                  w_last_word;
  logic                  w_last_byte;
  logic                  w_tx_start;
  logic                  w_busy;

  // A zero count has no words to send, so the first NEXT already ends it.
  assign w_word_next  = r_word_idx + (ADDR_W+1)'(1);
  assign w_shift_next = r_shift << 8;
  assign w_last_word  = (r_count == '0) || (w_word_next == r_count);
  assign w_last_byte  = (r_byte_idx == c_bidx_w'(c_bytes - 1));

  // State register; reset abandons any drain in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the state-derived outputs.
  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    w_busy       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.word_count == '0) ? NEXT : RD_ADDR;
        end
      end
      RD_ADDR: w_state_next = RD_WAIT;
      RD_WAIT: w_state_next = REQ;
      REQ: begin
        w_tx_start = 1'b1;
        // Only a busy that follows an idle sample is our own acknowledge.
        if (bus.tx_busy && r_armed) begin
          w_state_next = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (!bus.tx_busy) begin
          w_state_next = w_last_byte ? NEXT : REQ;
        end
      end
      NEXT:    w_state_next = w_last_word ? IDLE : RD_ADDR;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: word/byte indices, shift register, presented byte and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_tx_data  <= 8'h00;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_count    <= bus.word_count;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
        end
        RD_WAIT: begin
          r_shift   <= bus.mem_rdata;
          r_tx_data <= bus.mem_rdata[DATA_W-1 -: 8];
          r_armed   <= 1'b0;
        end
        REQ: begin
          if (!bus.tx_busy) begin
            r_armed <= 1'b1;
          end
        end
        ACK_WAIT: begin
          if (!bus.tx_busy) begin
            r_shift <= w_shift_next;
            r_armed <= 1'b0;
            if (w_last_byte) begin
              r_byte_idx <= '0;
            end else begin
              r_byte_idx <= r_byte_idx + c_bidx_w'(1);
              r_tx_data  <= w_shift_next[DATA_W-1 -: 8];
            end
          end
        end
        NEXT: begin
          r_word_idx <= w_word_next;
          r_done     <= w_last_word;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr = r_word_idx[ADDR_W-1:0];
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = w_tx_start;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_tx_serializer
//  Purpose  : Self-checking bench for result_tx_serializer with a result
//             memory model, a uart_tx busy model and a byte scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_tx_serializer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_tx_serializer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  result_tx_serializer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Result memory: synchronous read
  logic [31:0] mem [16];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  // Transmitter: accepts tx_start when idle, then stays busy busy_len cycles
  int   busy_cnt;
  int   busy_len;
  logic hold;
  always @(posedge clk) begin
    if (rst)                              busy_cnt <= 0;
    else if (busy_cnt != 0)               busy_cnt <= busy_cnt - 1;
    else if (bus.tx_start && !hold)       busy_cnt <= busy_len;
  end
  assign bus.tx_busy = (busy_cnt != 0) || hold;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int   checks;
  int   failures;
  int   start_rises;
  int   done_cnt;
  logic prev_start;
  logic prev_done;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected byte whenever the transmitter accepts one
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      prev_start = 1'b0;
      prev_done  = 1'b0;
      prev_data  = 8'h00;
    end else begin
      if (bus.tx_start && !prev_start) start_rises++;
      if (bus.tx_start && prev_start)
        check("tx_data_stable", 32'(bus.tx_data), 32'(prev_data));
      if (bus.tx_start && !bus.tx_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_byte actual=0x%0h required=none at %0t", bus.tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(e));
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_busy_low", 32'(bus.busy), 32'(0));
        check("done_width", 32'(prev_done), 32'(0));
        check("done_all_bytes_sent", 32'(exp_q.size()), 32'(0));
      end
      prev_start = bus.tx_start;
      prev_data  = bus.tx_data;
      prev_done  = bus.done;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  // Returns at the negedge right after the start edge
  task automatic do_start(input int n);
    @(negedge clk);
    bus.word_count = 5'(n);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    for (int i = 0; i < limit && bus.busy; i++) @(negedge clk);
    check(name, 32'(bus.busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic expect_counts(input string name, input int s0, input int d0, input int rises);
    check({name, "_tx_start_rises"}, 32'(start_rises - s0), 32'(rises));
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'(1));
  endtask

  initial begin
    int s0;
    int d0;
    checks = 0; failures = 0; start_rises = 0; done_cnt = 0;
    bus.start = 1'b0; bus.word_count = '0;
    hold = 1'b0; busy_len = 10;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_tx_data", 32'(bus.tx_data), 32'(0));
    rst = 1'b0;

    // Single word, 10-cycle transmitter, start-to-tx_start latency of 3
    mem[0] = 32'h12345678;
    push_word(mem[0]);
    s0 = start_rises; d0 = done_cnt;
    do_start(1);
    check("lat_rd_addr_tx_start", 32'(bus.tx_start), 32'(0));
    @(negedge clk);
    check("lat_rd_wait_tx_start", 32'(bus.tx_start), 32'(0));
    @(negedge clk);
    check("lat_req_tx_start", 32'(bus.tx_start), 32'(1));
    check("lat_req_tx_data", 32'(bus.tx_data), 32'h12);
    wait_done(400, "single_timeout");
    expect_counts("single", s0, d0, 4);

    // Zero count: done two cycles after start, nothing transmitted
    s0 = start_rises; d0 = done_cnt;
    do_start(0);
    check("zero_busy_next", 32'(bus.busy), 32'(1));
    check("zero_done_early", 32'(bus.done), 32'(0));
    @(negedge clk);
    check("zero_done", 32'(bus.done), 32'(1));
    check("zero_busy_low", 32'(bus.busy), 32'(0));
    @(negedge clk);
    check("zero_done_cleared", 32'(bus.done), 32'(0));
    check("zero_tx_start_rises", 32'(start_rises - s0), 32'(0));

    // Full matrix: 16 words, 64 bytes in address order
    busy_len = 2;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'(i) * 32'h01010101;
      push_word(mem[i]);
    end
    s0 = start_rises; d0 = done_cnt;
    do_start(16);
    wait_done(4000, "full_timeout");
    expect_counts("full", s0, d0, 64);
    check("full_mem_addr_wrap", 32'(bus.mem_addr), 32'(0));

    // Back-pressure: transmitter busy for 50 cycles before the first byte
    busy_len = 10;
    mem[0] = 32'h12345678;
    @(posedge clk); #1 hold = 1'b1;
    push_word(mem[0]);
    s0 = start_rises; d0 = done_cnt;
    do_start(1);
    repeat (10) @(negedge clk);
    check("bp_tx_start_held", 32'(bus.tx_start), 32'(1));
    check("bp_tx_data", 32'(bus.tx_data), 32'h12);
    repeat (40) @(negedge clk);
    check("bp_tx_start_held_late", 32'(bus.tx_start), 32'(1));
    check("bp_tx_data_late", 32'(bus.tx_data), 32'h12);
    check("bp_no_byte_yet", 32'(exp_q.size()), 32'(4));
    @(posedge clk); #1 hold = 1'b0;
    wait_done(400, "bp_timeout");
    expect_counts("bp", s0, d0, 4);

    // Ignored restart during a count-1 drain
    mem[0] = 32'hCAFEF00D; mem[1] = 32'h11111111; mem[2] = 32'h22222222;
    push_word(mem[0]);
    s0 = start_rises; d0 = done_cnt;
    do_start(1);
    repeat (5) @(negedge clk);
    bus.word_count = 5'd3;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    wait_done(400, "restart_timeout");
    repeat (20) @(negedge clk);
    expect_counts("restart", s0, d0, 4);
    check("restart_idle", 32'(bus.busy), 32'(0));

    // Reset mid-drain, then a fresh single-word drain
    mem[0] = 32'hA1B2C3D4; mem[1] = 32'h0;
    push_word(mem[0]); push_word(mem[1]);
    s0 = start_rises;
    do_start(2);
    for (int i = 0; i < 200 && (start_rises - s0) < 2; i++) @(negedge clk);
    check("mid_pre_reset_tx_start", 32'(bus.tx_start), 32'(1));
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("mid_reset_tx_start", 32'(bus.tx_start), 32'(0));
    check("mid_reset_busy", 32'(bus.busy), 32'(0));
    check("mid_reset_done", 32'(bus.done), 32'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_no_done", 32'(done_cnt - d0), 32'(0));
    mem[0] = 32'h5A6B7C8D;
    push_word(mem[0]);
    s0 = start_rises; d0 = done_cnt;
    do_start(1);
    wait_done(400, "mid_fresh_timeout");
    expect_counts("mid_fresh", s0, d0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
